regn_handshake_fifo: RTL
========================

Name: regn_handshake_fifo

Overview:
- Parametrised successor to the fixed 6-bit enable/done register.
- Input side: captures WIDTH-bit words over a four-phase req/ack handshake.
- Storage: buffers up to DEPTH words.
- Output side: presents words on a valid/ready interface.
- Placement: decouples a slow, handshake-driven producer (e.g. a switch/FSM front end) from a streaming consumer in the course datapaths.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, buffer entries; power of two, >=2
CW, $clog2(DEPTH+1), width of level output (derived, localparam)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  1  producer request (four-phase)
data_in  input  WIDTH  producer data; stable while req=1
ack  output  1  capture acknowledge (four-phase)
out_valid  output  1  head word available
out_ready  input  1  consumer accepts head word
data_out  output  WIDTH  head word; 0 when empty
level  output  CW  number of stored words
full  output  1  level==DEPTH
empty  output  1  level==0
err  output  1  sticky data-change error (CHECK_EN only; else 0)

Behaviour:
- Clocking and reset: rst is asynchronous, active-high; clk is the clock. All state updates on the rising edge of clk.
- Reset values: state=IDLE, ack=0, wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, out_valid=0, data_out=0, err=0. Memory contents are not reset.
- Input FSM, state IDLE (ack=0):
  - req=1 and full=0 at an edge: write data_in at wr_ptr, wr_ptr+1, go to ACK. ack reads 1 after that edge (1-cycle latency).
  - req=1 and full=1: stay in IDLE, no write (stall).
  - full is the pre-edge value. A pop in the same cycle does not unblock the write; the write happens next cycle.
- Input FSM, state ACK (ack=1):
  - Hold while req=1. No further writes.
  - req=0 at an edge: go to IDLE. ack reads 0 after that edge.
  - A new capture needs req to go low then high again. Exactly one word per handshake.
- Output side:
  - out_valid = !empty. data_out = mem[rd_ptr] when out_valid, else 0 (combinational show-ahead).
  - Pop when out_valid & out_ready at an edge: rd_ptr+1.
  - out_ready while empty is ignored.
- Level:
  - write only: +1. pop only: -1. write and pop in the same edge: unchanged.
  - Never exceeds DEPTH, never underflows.
- Pointers: log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- No bypass: a word written into an empty buffer is visible on out_valid/data_out one cycle after the write edge.
- Reset mid-handshake: ack drops immediately. Buffered words are discarded. Producer must drop req and restart.
- All outputs except data_out (combinational from registered state) are registered or derived from registers. No combinational path from req/out_ready to any output.

Optional Feature:
- Macro: REGN_HANDSHAKE_CHECK_EN.
- Defined:
  - The word captured on the IDLE->ACK transition is also held in a compare register.
  - In ACK with req=1, if data_in != compare register at an edge, err is set to 1.
  - err is sticky; it is cleared only by rst.
  - Storage and handshake are unaffected.
- Undefined: no compare register, and err is tied to 0.

Test Plan:
- Reset, then single handshake: req=1, data_in=8'hA5 -> ack=1 one cycle later, out_valid=1, data_out=8'hA5, level=1. Then req=0 -> ack=0 next cycle. Then out_ready=1 for one cycle -> empty=1, data_out=0.
- Fill: 4 handshakes with 8'h11, 8'h22, 8'h33, 8'h44, out_ready=0 -> full=1, level=4. Fifth req=1 with 8'h55 -> ack stays 0. Pop one -> 8'h55 captured one cycle later. Drain order 22, 33, 44, 55.
- Wrap: 10 handshake+pop pairs with values 0..9 -> outputs 0..9 in order, level returns to 0, no loss across pointer wrap.
- Simultaneous: level=2; handshake write and pop on the same edge -> level stays 2, head advances correctly.
- Async reset: assert rst mid-ACK with level=3 -> ack=0, level=0, empty=1, out_valid=0 without waiting for a clock edge.
- CHECK_EN: capture 8'h3C, change data_in to 8'h3D while req=1 -> err=1 and stays 1 after req=0. rst clears it. Without the macro, err=0 throughout.

Source files
------------

// File: rtl/regn_handshake_fifo.sv
// Four-phase req/ack capture into a DEPTH-entry buffer, drained over valid/ready.
// Define REGN_HANDSHAKE_CHECK_EN to flag data_in changing while req is held.
module regn_handshake_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] data_in,
    output logic             ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic             err
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {IDLE, ACK} state_e;

    state_e           state_q;
    logic             ack_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    level_q, level_d;
    logic             full_q, empty_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en, pop;

    // full_q is the pre-edge value, so a same-cycle pop never unblocks a write
    assign wr_en = (state_q == IDLE) && req && !full_q;
    assign pop   = !empty_q && out_ready;

    always_comb begin
        level_d = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (req && !full_q) begin
                    state_q  <= ACK;
                    ack_q    <= 1'b1;
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                ACK: if (!req) begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            full_q  <= (level_d == CW'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_in;
    end

`ifdef REGN_HANDSHAKE_CHECK_EN
    logic [WIDTH-1:0] cmp_q;
    logic             err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (wr_en) cmp_q <= data_in;
            if (state_q == ACK && req && data_in != cmp_q) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ack       = ack_q;
    assign out_valid = !empty_q;
    assign data_out  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign level     = level_q;
    assign full      = full_q;
    assign empty     = empty_q;

endmodule
